// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square
// wave in clk_50m cycles, with valid/ack handoff, sticky overrun and timeout.
module period_meter #(
    parameter int WIDTH     = 25,
    parameter int MAX_COUNT = 25_000_000
) (
    input  logic             clk_50m,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             ack,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overrun,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_tmp_q, hi_tmp_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic             rise;
    logic             fall;
    logic             at_max;
    logic             result;
    logic [WIDTH-1:0] cnt_inc;

    assign rise   = s2_q & ~s3_q;
    assign fall   = ~s2_q & s3_q;
    assign at_max = (cnt_q == CNT_MAX);
    // Saturate so the counter can never pass the timeout limit or wrap.
    assign cnt_inc = at_max ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        s1_d      = sig_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_tmp_d  = hi_tmp_q;
        period_d  = period_q;
        high_d    = high_q;
        timeout_d = 1'b0;
        result    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    hi_tmp_d = cnt_q;
                    cnt_d    = cnt_inc;
                    state_d  = MEAS_LOW;
                end else if (at_max) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_tmp_q;
                    result   = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = MEAS_HIGH;
                end else if (at_max) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A result landing together with ack is a clean handoff, not an overrun.
        valid_d   = result | (valid_q & ~ack);
        overrun_d = overrun_q | (result & valid_q & ~ack);
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            hi_tmp_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            cnt_q     <= cnt_d;
            hi_tmp_q  <= hi_tmp_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: table vectors, directed corner sequences and random
// waves checked every cycle against a timestamp-based reference model.
module tb_period_meter;

    localparam int W    = 8;
    localparam int MAXC = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sig_in = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         overrun;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    period_meter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
        .clk_50m   (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .ack       (ack),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    // Reference model: sig_in sample per edge, edges seen two samples late,
    // measurements kept as timestamps of the rise and fall edges.
    bit           hist[$] = '{1'b0, 1'b0, 1'b0};
    bit           m_meas = 1'b0;
    bit           m_have_fall = 1'b0;
    int           t0 = 0;
    int           tf = 0;
    int           res_cnt = 0;
    bit           ev_result = 1'b0;
    logic [W-1:0] exp_per = '0;
    logic [W-1:0] exp_hi = '0;
    logic         exp_valid = 1'b0;
    logic         exp_ovr = 1'b0;
    logic         exp_to = 1'b0;

    task automatic model_edge();
        int  k;
        int  d;
        bit  rise;
        bit  fall;
        bit  res;
        k = hist.size();
        hist.push_back(reset ? 1'b0 : sig_in);
        ev_result = 1'b0;
        if (reset) begin
            hist[k-1]   = 1'b0;
            hist[k-2]   = 1'b0;
            m_meas      = 1'b0;
            m_have_fall = 1'b0;
            res_cnt     = 0;
            exp_per     = '0;
            exp_hi      = '0;
            exp_valid   = 1'b0;
            exp_ovr     = 1'b0;
            exp_to      = 1'b0;
        end else begin
            rise   = hist[k-2] && !hist[k-3];
            fall   = !hist[k-2] && hist[k-3];
            d      = k - t0;
            res    = 1'b0;
            exp_to = 1'b0;
            if (!m_meas) begin
                if (rise) begin
                    m_meas      = 1'b1;
                    m_have_fall = 1'b0;
                    t0          = k;
                end
            end else if (!m_have_fall) begin
                if (fall) begin
                    m_have_fall = 1'b1;
                    tf          = k;
                end else if (d >= MAXC) begin
                    exp_to = 1'b1;
                    m_meas = 1'b0;
                end
            end else begin
                if (rise) begin
                    res         = 1'b1;
                    exp_ovr     = exp_ovr | (exp_valid & ~ack);
                    exp_per     = W'(d);
                    exp_hi      = W'(tf - t0);
                    t0          = k;
                    m_have_fall = 1'b0;
                end else if (d >= MAXC) begin
                    exp_to = 1'b1;
                    m_meas = 1'b0;
                end
            end
            if (res) begin
                exp_valid = 1'b1;
                res_cnt++;
            end else if (ack) begin
                exp_valid = 1'b0;
            end
            ev_result = res;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if ({period, high_time, valid, overrun, timeout} !==
            {exp_per, exp_hi, exp_valid, exp_ovr, exp_to}) begin
            errors++;
            $display("FAIL cyc@%0t: got per=%0d hi=%0d v=%b ovr=%b to=%b, want per=%0d hi=%0d v=%b ovr=%b to=%b",
                     $time, period, high_time, valid, overrun, timeout,
                     exp_per, exp_hi, exp_valid, exp_ovr, exp_to);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sig_in = 1'b0;
        ack    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        int hi;
        int lo;
        bit ackv;
        int nres;
        int per;
        int ht;
        bit ovr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int  c;
        int  to_cnt;
        int  to_at;
        int  first_v;
        bit  found;
        bit  vseen;
        int  hi;
        int  lo;
        int  reps;

        tbl[0] = '{4, 4, 1'b1, 2, 8, 4, 1'b0};
        tbl[1] = '{3, 7, 1'b0, 1, 10, 3, 1'b0};
        tbl[2] = '{3, 7, 1'b0, 2, 10, 3, 1'b1};
        tbl[3] = '{5, 5, 1'b1, 1, 10, 5, 1'b0};
        tbl[4] = '{2, 2, 1'b0, 3, 4, 2, 1'b1};
        tbl[5] = '{6, 13, 1'b1, 1, 19, 6, 1'b0};
        tbl[6] = '{10, 10, 1'b1, 1, 20, 10, 1'b0};

        do_reset();
        chk("reset_valid", int'(valid), 0);

        foreach (tbl[i]) begin
            do_reset();
            found = 1'b0;
            for (int k = 0; k < 200 && !found; k++) begin
                sig_in = (k % (tbl[i].hi + tbl[i].lo)) < tbl[i].hi;
                ack    = tbl[i].ackv;
                step();
                if (ev_result && res_cnt == tbl[i].nres) begin
                    found = 1'b1;
                    chk($sformatf("tbl%0d_period", i), int'(period), tbl[i].per);
                    chk($sformatf("tbl%0d_high", i), int'(high_time), tbl[i].ht);
                    chk($sformatf("tbl%0d_valid", i), int'(valid), 1);
                    chk($sformatf("tbl%0d_overrun", i), int'(overrun), int'(tbl[i].ovr));
                end
            end
            if (!found) chk($sformatf("tbl%0d_bound", i), 0, 1);
        end

        // sig_in high through reset release, then stuck high
        reset  = 1'b1;
        sig_in = 1'b1;
        ack    = 1'b0;
        step();
        step();
        reset  = 1'b0;
        to_cnt = 0;
        to_at  = -1;
        vseen  = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (timeout === 1'b1) begin
                to_cnt++;
                if (to_at < 0) to_at = k;
            end
            if (valid !== 1'b0) vseen = 1'b1;
        end
        chk("stuck_hi_to_count", to_cnt, 1);
        chk("stuck_hi_to_cycle", to_at, 23);
        chk("stuck_hi_valid", int'(vseen), 0);

        // one high pulse, then stuck low
        do_reset();
        to_cnt = 0;
        to_at  = -1;
        for (int k = 1; k <= 60; k++) begin
            sig_in = (k >= 3 && k <= 6);
            step();
            if (timeout === 1'b1) begin
                to_cnt++;
                if (to_at < 0) to_at = k;
            end
        end
        chk("stuck_lo_to_count", to_cnt, 1);
        chk("stuck_lo_to_cycle", to_at, 25);

        // ack in the very cycle a second result lands
        do_reset();
        c     = 0;
        found = 1'b0;
        while (c < 60 && !found) begin
            sig_in = (c % 10) < 3;
            ack    = 1'b0;
            step();
            found = ev_result;
            c++;
        end
        if (!found) chk("ack_same_bound", 0, 1);
        for (int j = 1; j <= 10; j++) begin
            sig_in = (c % 10) < 3;
            ack    = (j == 10);
            step();
            c++;
        end
        ack = 1'b0;
        chk("ack_same_valid", int'(valid), 1);
        chk("ack_same_overrun", int'(overrun), 0);
        chk("ack_same_period", int'(period), 10);

        // reset pulse during the low phase of a 5/5 wave
        do_reset();
        c = 0;
        while (res_cnt < 2 && c < 100) begin
            sig_in = (c % 10) < 5;
            ack    = 1'b1;
            step();
            c++;
        end
        if (res_cnt < 2) chk("mid_rst_bound", 0, 1);
        while (c % 10 != 8) begin
            sig_in = (c % 10) < 5;
            step();
            c++;
        end
        reset  = 1'b1;
        sig_in = 1'b0;
        ack    = 1'b0;
        step();
        reset = 1'b0;
        c++;
        chk("mid_rst_zero", int'({period, high_time, valid, overrun, timeout}), 0);
        first_v = -1;
        for (int j = 1; j <= 40; j++) begin
            sig_in = (c % 10) < 5;
            step();
            c++;
            if (valid === 1'b1 && first_v < 0) begin
                first_v = j;
                chk("mid_rst_period", int'(period), 10);
                chk("mid_rst_high", int'(high_time), 5);
            end
        end
        chk("mid_rst_first_valid", first_v, 14);

        // random waves, random ack, occasional reset
        do_reset();
        for (int s = 0; s < 400; s++) begin
            hi   = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(2, 12));
            lo   = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(2, 12));
            reps = $urandom_range(1, 3);
            for (int k = 0; k < reps * (hi + lo); k++) begin
                sig_in = (k % (hi + lo)) < hi;
                ack    = ($urandom_range(0, 3) == 0);
                step();
            end
            if ($urandom_range(0, 29) == 0) begin
                reset  = 1'b1;
                sig_in = 1'b0;
                step();
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 25, giving the counter and result width in bits.
REQ-002 The block SHALL have parameter MAX_COUNT, default 25_000_000, giving the timeout limit in clk_50m cycles (0.5 s).
REQ-003 clk_50m  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk_50m rising edge.
REQ-005 sig_in  input  1  slow square wave, asynchronous to clk_50m (e.g. a divided clock) to be measured.
REQ-006 ack  input  1  consumer acknowledge; clears valid.
REQ-007 period  output  WIDTH  last full period in clk_50m cycles (rise to rise).
REQ-008 high_time  output  WIDTH  high phase of that period in clk_50m cycles (rise to fall).
REQ-009 valid  output  1  period/high_time hold an unacknowledged result.
REQ-010 overrun  output  1  sticky; a result was overwritten while valid=1 and no ack.
REQ-011 timeout  output  1  one-cycle pulse; no expected edge arrived within MAX_COUNT cycles.

Function
REQ-012 sig_in SHALL pass through a two-flop synchronizer (s1, s2) and a history flop (s3): rise = s2 & ~s3; fall = ~s2 & s3.
REQ-013 Edge detection latency SHALL be 3 clk_50m cycles from an sig_in change to the rise/fall pulse.
REQ-014 FSM states SHALL be IDLE, MEAS_HIGH and MEAS_LOW; the reset state SHALL be IDLE.
REQ-015 IDLE: on rise, the FSM SHALL set cnt to 1 and go to MEAS_HIGH; cnt SHALL hold 0 otherwise.
REQ-016 MEAS_HIGH: cnt SHALL increment every cycle; on fall, the FSM SHALL latch hi_tmp = cnt, keep incrementing, and go to MEAS_LOW.
REQ-017 MEAS_LOW: on rise, the FSM SHALL load period = cnt and high_time = hi_tmp, set valid to 1, reload cnt to 1, and stay in the measuring loop (go to MEAS_HIGH).
REQ-018 For consecutive rise pulses at cycles t0 and t1, period SHALL equal t1-t0; for a fall at tf, high_time SHALL equal tf-t0.
REQ-019 Outputs SHALL update on the clock edge at which the rise pulse is seen; valid SHALL be visible the next cycle.
REQ-020 Timeout: if cnt equals MAX_COUNT in MEAS_HIGH or MEAS_LOW with no edge, the block SHALL pulse timeout for 1 cycle, clear cnt, and go to IDLE.
REQ-021 On timeout, period, high_time and valid SHALL be left unchanged.
REQ-022 cnt SHALL never exceed MAX_COUNT and SHALL never wrap; MAX_COUNT SHALL be at most 2^WIDTH-1.
REQ-023 ack=1 SHALL clear valid on the next edge; ack while valid=0 SHALL be ignored.
REQ-024 Simultaneous ack and a new result SHALL leave valid=1 with the new data, and overrun SHALL NOT be set.
REQ-025 A new result while valid=1 and ack=0 SHALL overwrite period/high_time and set overrun, which stays 1 until reset.
REQ-026 sig_in stuck high or stuck low SHALL produce exactly one timeout per measurement attempt, then the block waits in IDLE.
REQ-027 The first rise after reset or timeout SHALL only start a measurement and SHALL NOT produce a result.

Reset
REQ-028 When reset=1, the block SHALL set the FSM to IDLE; cnt, hi_tmp, period, high_time to 0; and valid, overrun, timeout to 0.
REQ-029 When reset=1, the block SHALL load s1, s2, s3 with 0, so a sig_in already high at reset release yields a rise 3 cycles later.
REQ-030 Reset asserted mid-measurement SHALL discard the partial count; no result or timeout SHALL be produced for it.
REQ-031 Reset SHALL take priority over ack, edge and timeout events in the same cycle.

Verification
REQ-032 sig_in square wave 4 high / 4 low cycles, ack held 1 -> after the second rise: period=8, high_time=4, one valid per period, overrun=0.
REQ-033 sig_in 3 high / 7 low, ack=0 -> first result period=10, high_time=3, valid=1; next rise overwrites with the same values and overrun=1.
REQ-034 MAX_COUNT=20, sig_in rises once then stays high -> timeout pulses exactly 1 cycle, 20 cycles after the rise pulse; valid stays 0; FSM returns to IDLE.
REQ-035 ack asserted in the same cycle as a result completes -> valid remains 1, new values present, overrun=0.
REQ-036 reset pulsed for 1 cycle during MEAS_LOW of a 5/5 wave -> all outputs 0; the first result after reset is period=10, high_time=5 and appears on the second post-reset rise.
